pixel_gen_multi: RTL and testbench

PIXEL_GEN_MULTI -- requirements
Module: pixel_gen_multi

---
 rtl/pixel_gen_multi.sv | 161 ++++++++++++++++
 tb/tb_pixel_gen_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_gen_multi.sv
// Player square plus falling target squares with catch scoring and a registered RGB444 pixel path.
// Define PIXEL_GEN_PAUSE_EN to add a pause input that freezes motion and scoring.
module pixel_gen_multi #(
  parameter int          N_OBJ    = 4,
  parameter int          OBJ_SIZE = 16,
  parameter int          STEP     = 2,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       video_on,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       right_k,
  input  logic       left_k,
`ifdef PIXEL_GEN_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [3:0] score,
  output logic       score_tick
);

  localparam logic [10:0] SIZE_W    = 11'(OBJ_SIZE);
  localparam logic [10:0] X_MAX     = 11'(640 - OBJ_SIZE);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] Y_BOTTOM  = 11'd480;
  localparam logic [9:0]  PLAYER_Y  = 10'(480 - OBJ_SIZE - 8);
  localparam logic [9:0]  PLAYER_X0 = 10'((640 - OBJ_SIZE) / 2);

  logic [9:0]  x_q [N_OBJ];
  logic [9:0]  x_d [N_OBJ];
  logic [9:0]  y_q [N_OBJ];
  logic [9:0]  y_d [N_OBJ];
  logic [3:0]  score_q, score_d;
  logic        score_tick_q, score_tick_d;
  logic [11:0] rgb_q, rgb_d;
  logic        frame_tick;
  logic        move_en;
  logic [2:0]  n_caught;

  function automatic logic [9:0] player_next(input logic [9:0] x, input logic rk,
                                             input logic lk);
    logic [10:0] xe;
    logic [10:0] res;
    xe  = {1'b0, x};
    res = xe;
    if (rk && !lk) begin
      res = (xe + STEP_W > X_MAX) ? X_MAX : xe + STEP_W;
    end else if (lk && !rk) begin
      res = (xe < STEP_W) ? 11'd0 : xe - STEP_W;
    end
    return 10'(res);
  endfunction

  // Positions always stay below X_MAX, so one conditional subtract implements the modulo.
  function automatic logic [9:0] respawn_x(input logic [9:0] x);
    logic [10:0] sum;
    sum = {1'b0, x} + 11'd96;
    if (sum >= X_MAX) sum = sum - X_MAX;
    return 10'(sum);
  endfunction

  // Rectangles touching on an edge count as overlapping.
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    return ({1'b0, ax} <= {1'b0, bx} + SIZE_W) && ({1'b0, bx} <= {1'b0, ax} + SIZE_W) &&
           ({1'b0, ay} <= {1'b0, by} + SIZE_W) && ({1'b0, by} <= {1'b0, ay} + SIZE_W);
  endfunction

  function automatic logic hit(input logic [9:0] ox, input logic [9:0] oy,
                               input logic [9:0] px, input logic [9:0] py);
    return ({1'b0, ox} <= {1'b0, px}) && ({1'b0, px} < {1'b0, ox} + SIZE_W) &&
           ({1'b0, oy} <= {1'b0, py}) && ({1'b0, py} < {1'b0, oy} + SIZE_W);
  endfunction

  function automatic logic [11:0] obj_color(input int k);
    logic [11:0] c;
    case (k)
      0:       c = 12'h00F;
      1:       c = 12'hF00;
      2:       c = 12'h0F0;
      default: c = 12'hF0F;
    endcase
    return c;
  endfunction

  assign frame_tick = p_tick && (pixel_y == 10'd481) && (pixel_x == 10'd0);
`ifdef PIXEL_GEN_PAUSE_EN
  assign move_en = frame_tick && !pause;
`else
  assign move_en = frame_tick;
`endif

  // Catches are judged on the pre-move positions of both player and target.
  always_comb begin
    n_caught     = 3'd0;
    score_d      = score_q;
    score_tick_d = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    if (move_en) begin
      x_d[0] = player_next(x_q[0], right_k, left_k);
      for (int i = 1; i < N_OBJ; i++) begin
        if (overlap(x_q[i], y_q[i], x_q[0], y_q[0])) begin
          n_caught = n_caught + 3'd1;
          x_d[i]   = respawn_x(x_q[i]);
          y_d[i]   = 10'd0;
        end else if ({1'b0, y_q[i]} + 11'(i) + SIZE_W >= Y_BOTTOM) begin
          x_d[i] = respawn_x(x_q[i]);
          y_d[i] = 10'd0;
        end else begin
          y_d[i] = y_q[i] + 10'(i);
        end
      end
      score_d      = score_q + 4'(n_caught);
      score_tick_d = (n_caught != 3'd0);
    end
  end

  // Lowest index is applied last so it wins overlaps.
  always_comb begin
    rgb_d = BG_COLOR;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (hit(x_q[k], y_q[k], pixel_x, pixel_y)) rgb_d = obj_color(k);
    end
    if (!video_on) rgb_d = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i] <= (i == 0) ? PLAYER_X0 : 10'(i * 128);
        y_q[i] <= (i == 0) ? PLAYER_Y : 10'd0;
      end
      score_q      <= 4'd0;
      score_tick_q <= 1'b0;
      rgb_q        <= 12'h000;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      score_q      <= score_d;
      score_tick_q <= score_tick_d;
      rgb_q        <= rgb_d;
    end
  end

  assign r          = rgb_q[11:8];
  assign g          = rgb_q[7:4];
  assign b          = rgb_q[3:0];
  assign score      = score_q;
  assign score_tick = score_tick_q;

endmodule

// File: tb/tb_pixel_gen_multi.sv
// Randomized bench for pixel_gen_multi against a frame-level game model.
module tb_pixel_gen_multi;
  localparam int          S    = 16;
  localparam int          STEP = 2;
  localparam int          N    = 4;
  localparam logic [11:0] BG   = 12'hFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       video_on = 1'b0;
  logic       p_tick = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       right_k = 1'b0;
  logic       left_k = 1'b0;
`ifdef PIXEL_GEN_PAUSE_EN
  logic       pause_i = 1'b0;
`endif
  logic [3:0] r, g, b, score;
  logic       score_tick;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  int mx[N];
  int my[N];
  int mscore;
  int catches;

  pixel_gen_multi #(.N_OBJ(N), .OBJ_SIZE(S), .STEP(STEP), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .right_k(right_k), .left_k(left_k),
`ifdef PIXEL_GEN_PAUSE_EN
    .pause(pause_i),
`endif
    .r(r), .g(g), .b(b), .score(score), .score_tick(score_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // reference model: the game rules at frame granularity
  function automatic void model_reset();
    mx[0] = (640 - S) / 2;
    my[0] = 480 - S - 8;
    for (int i = 1; i < N; i++) begin
      mx[i] = i * 128;
      my[i] = 0;
    end
    mscore = 0;
  endfunction

  function automatic int model_tick(input bit rk, input bit lk);
    int caught;
    int px;
    int py;
    bit touch;
    caught = 0;
    px = mx[0];
    py = my[0];
    for (int i = 1; i < N; i++) begin
      touch = (mx[i] <= px + S) && (px <= mx[i] + S) && (my[i] <= py + S) && (py <= my[i] + S);
      if (touch) caught++;
      if (touch || my[i] + i + S >= 480) begin
        my[i] = 0;
        mx[i] = (mx[i] + 96) % (640 - S);
      end else begin
        my[i] = my[i] + i;
      end
    end
    if (rk && !lk) mx[0] = (mx[0] + STEP > 640 - S) ? 640 - S : mx[0] + STEP;
    if (lk && !rk) mx[0] = (mx[0] - STEP < 0) ? 0 : mx[0] - STEP;
    mscore = (mscore + caught) % 16;
    return caught;
  endfunction

  function automatic logic [11:0] obj_color(input int k);
    case (k)
      0: return 12'h00F;
      1: return 12'hF00;
      2: return 12'h0F0;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit v);
    if (!v) return 12'h000;
    for (int k = 0; k < N; k++)
      if (x >= mx[k] && x < mx[k] + S && y >= my[k] && y < my[k] + S) return obj_color(k);
    return BG;
  endfunction

  // chase whichever target is lowest on screen
  function automatic void steer(output bit rk, output bit lk);
    int t;
    t = 1;
    for (int i = 2; i < N; i++) if (my[i] > my[t]) t = i;
    rk = mx[t] > mx[0] + 1;
    lk = mx[t] + 1 < mx[0];
  endfunction

  // driver tasks
  task automatic drive(input bit pt, input int x, input int y, input bit v, input bit rk,
                       input bit lk);
    @(negedge clk);
    p_tick = pt;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = v;
    right_k = rk;
    left_k = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string tag, input int x, input int y, input bit v);
    exp_q.push_back(model_rgb(x, y, v));
    drive(1'($urandom_range(0, 1)), x, y, v, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    check(tag, 32'({r, g, b}), 32'(exp_q.pop_front()));
  endtask

  task automatic probe_const(input string tag, input int x, input int y, input bit v,
                             input logic [11:0] exp);
    drive(1'b0, x, y, v, 1'b0, 1'b0);
    check(tag, 32'({r, g, b}), 32'(exp));
  endtask

  task automatic probe_objects();
    for (int k = 0; k < N; k++) begin
      probe("obj_tl", mx[k], my[k], 1'b1);
      probe("obj_br", mx[k] + S - 1, my[k] + S - 1, 1'b1);
      probe("obj_right", mx[k] + S, my[k], 1'b1);
      if (mx[k] > 0) probe("obj_left", mx[k] - 1, my[k] + S - 1, 1'b1);
      if (my[k] > 0) probe("obj_above", mx[k], my[k] - 1, 1'b1);
    end
    probe("rand_px", int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
          1'($urandom_range(0, 3) != 0));
  endtask

  task automatic frame_tick(input bit rk, input bit lk, input bit ps);
    int caught;
    caught = ps ? 0 : model_tick(rk, lk);
    catches += caught;
`ifdef PIXEL_GEN_PAUSE_EN
    pause_i = ps;
`endif
    drive(1'b1, 0, 481, 1'b1, rk, lk);
    check("score", 32'(score), 32'(mscore));
    check("tick_pulse", 32'(score_tick), 32'(caught > 0));
    drive(1'b0, 0, 481, 1'b0, 1'b0, 1'b0);
    check("tick_clear", 32'(score_tick), 32'd0);
    check("blank", 32'({r, g, b}), 32'(model_rgb(0, 481, 1'b0)));
  endtask

  task automatic do_reset(input bit on_tick);
    @(negedge clk);
    rst = 1'b1;
    p_tick = on_tick;
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    video_on = 1'b1;
    right_k = 1'b1;
    left_k = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_score", 32'(score), 32'd0);
    check("rst_tick", 32'(score_tick), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    p_tick = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rk;
    bit lk;
    int n;
    catches = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // reset picture
    probe_const("rst_player_px", 312, 456, 1'b1, 12'h00F);
    probe_const("rst_bg_px", 0, 0, 1'b1, 12'hFFF);
    probe_const("rst_video_off", 312, 456, 1'b0, 12'h000);
    probe_objects();

    // right clamp, then both keys held
    for (int t = 0; t < 200; t++) begin
      frame_tick(1'b1, 1'b0, 1'b0);
      if (t % 25 == 0) probe_objects();
    end
    probe_const("player_clamp_l", 624, 456, 1'b1, 12'h00F);
    probe_const("player_clamp_r", 639, 471, 1'b1, 12'h00F);
    probe("player_clamp_edge", 623, 456, 1'b1);
    for (int t = 0; t < 5; t++) frame_tick(1'b1, 1'b1, 1'b0);
    probe_objects();

    // target 3 fall and respawn
    do_reset(1'b0);
    for (int t = 0; t < 154; t++) frame_tick(1'b0, 1'b0, 1'b0);
    probe_const("t3_y462", 384, 462, 1'b1, 12'hF0F);
    probe("t3_above", 384, 461, 1'b1);
    frame_tick(1'b0, 1'b0, 1'b0);
    probe_const("t3_respawn", 480, 0, 1'b1, 12'hF0F);
    probe("t3_old_spot", 384, 462, 1'b1);
    probe_objects();

    // player under target 1 until the first catch
    do_reset(1'b0);
    for (int t = 0; t < 92; t++) frame_tick(1'b0, 1'b1, 1'b0);
    probe_const("player_at_128", 128, 456, 1'b1, 12'h00F);
    n = 0;
    while (mscore == 0 && n < 600) begin
      frame_tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    probe_const("t1_respawn", mx[1], 0, 1'b1, 12'hF00);
    probe_objects();

    // chase targets until the score has wrapped
    catches = 0;
    n = 0;
    while (catches < 20 && n < 6000) begin
      steer(rk, lk);
      if ($urandom_range(0, 7) == 0) begin
        rk = 1'($urandom_range(0, 1));
        lk = 1'($urandom_range(0, 1));
      end
      frame_tick(rk, lk, 1'b0);
      n++;
    end
    probe_objects();

    // random play with full probing
    for (int t = 0; t < 150; t++) begin
      steer(rk, lk);
      if ($urandom_range(0, 3) == 0) begin
        rk = 1'($urandom_range(0, 1));
        lk = 1'($urandom_range(0, 1));
      end
      frame_tick(rk, lk, 1'b0);
      probe_objects();
    end

    // reset coinciding with a frame tick, then a normal first tick
    do_reset(1'b1);
    probe_objects();
    frame_tick(1'b1, 1'b0, 1'b0);
    probe_objects();

`ifdef PIXEL_GEN_PAUSE_EN
    for (int t = 0; t < 60; t++) frame_tick(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 10; t++) begin
      frame_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      probe_objects();
    end
    frame_tick(1'b1, 1'b0, 1'b0);
    probe_objects();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
